// File: rtl/uart_rx_hex_display.sv
// 8N1 UART receiver feeding a scrolling hex history on NUM_DIGITS seven-segment digits.
// Define UART_RX_ASCII_HEX_EN to shift in ASCII hex characters instead of raw bytes.
module uart_rx_hex_display #(
  parameter int CLKS_PER_BIT = 217,
  parameter int NUM_DIGITS   = 4
) (
  input  logic                    i_Clk,
  input  logic                    i_Reset,
  input  logic                    i_UART_RX,
  input  logic                    i_Clear,
  output logic                    o_RX_DV,
  output logic [7:0]              o_RX_Byte,
  output logic                    o_Frame_Err,
  output logic [7*NUM_DIGITS-1:0] o_Segments
);

  localparam int CNT_W  = $clog2(CLKS_PER_BIT);
  localparam int HIST_W = 4 * NUM_DIGITS;
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, CLEANUP} state_t;

  state_t             state, state_next;
  logic [CNT_W-1:0]   clk_cnt, cnt_next;
  logic [2:0]         bit_idx, bit_next;
  logic [7:0]         shift_reg, shift_next;
  logic [7:0]         rx_byte, byte_next;
  logic               rx_dv, dv_next;
  logic               frame_err, fe_next;
  logic               rx_meta, rx_sync;
  logic [HIST_W-1:0]  hist;
  logic [7*NUM_DIGITS-1:0] seg_next, segments;

  // Idle-high line, so the synchronizer powers up in the idle state.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= i_UART_RX;
      rx_sync <= rx_meta;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state     <= IDLE;
      clk_cnt   <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      rx_byte   <= '0;
      rx_dv     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_next;
      clk_cnt   <= cnt_next;
      bit_idx   <= bit_next;
      shift_reg <= shift_next;
      rx_byte   <= byte_next;
      rx_dv     <= dv_next;
      frame_err <= fe_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = clk_cnt;
    bit_next   = bit_idx;
    shift_next = shift_reg;
    byte_next  = rx_byte;
    dv_next    = 1'b0;
    fe_next    = 1'b0;
    case (state)
      IDLE: begin
        cnt_next = '0;
        bit_next = '0;
        if (!rx_sync) state_next = START;
      end
      START: begin
        if (clk_cnt == HALF_CNT) begin
          cnt_next   = '0;
          state_next = rx_sync ? IDLE : DATA;
        end else begin
          cnt_next = clk_cnt + 1'b1;
        end
      end
      DATA: begin
        if (clk_cnt == LAST_CNT) begin
          cnt_next   = '0;
          shift_next = {rx_sync, shift_reg[7:1]};
          if (bit_idx == 3'd7) state_next = STOP;
          else                 bit_next   = bit_idx + 1'b1;
        end else begin
          cnt_next = clk_cnt + 1'b1;
        end
      end
      STOP: begin
        if (clk_cnt == LAST_CNT) begin
          cnt_next   = '0;
          state_next = CLEANUP;
          if (rx_sync) begin
            byte_next = shift_reg;
            dv_next   = 1'b1;
          end else begin
            fe_next = 1'b1;
          end
        end else begin
          cnt_next = clk_cnt + 1'b1;
        end
      end
      CLEANUP: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

`ifdef UART_RX_ASCII_HEX_EN
  logic       is_hex;
  logic [3:0] nibble;

  // Letters map as low nibble + 9, which holds for both 'A'..'F' and 'a'..'f'.
  always_comb begin
    is_hex = 1'b1;
    nibble = 4'h0;
    if (rx_byte >= 8'h30 && rx_byte <= 8'h39)
      nibble = rx_byte[3:0];
    else if ((rx_byte >= 8'h41 && rx_byte <= 8'h46) || (rx_byte >= 8'h61 && rx_byte <= 8'h66))
      nibble = rx_byte[3:0] + 4'd9;
    else
      is_hex = 1'b0;
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset || i_Clear)
      hist <= '0;
    else if (rx_dv) begin
      if (rx_byte == 8'h0D) hist <= '0;
      else if (is_hex)      hist <= {hist[HIST_W-5:0], nibble};
    end
  end
`else
  logic [HIST_W-1:0] raw_next;

  // With only two digits the whole history is the newest byte.
  if (NUM_DIGITS > 2) begin : g_wide
    assign raw_next = {hist[HIST_W-9:0], rx_byte};
  end else begin : g_narrow
    assign raw_next = rx_byte;
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset || i_Clear) hist <= '0;
    else if (rx_dv)         hist <= raw_next;
  end
`endif

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
    endcase
  endfunction

  always_comb begin
    seg_next = '0;
    for (int d = 0; d < NUM_DIGITS; d++)
      seg_next[7*d +: 7] = hex7(hist[4*d +: 4]);
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) segments <= {NUM_DIGITS{7'h3F}};
    else         segments <= seg_next;
  end

  assign o_RX_DV     = rx_dv;
  assign o_RX_Byte   = rx_byte;
  assign o_Frame_Err = frame_err;
  assign o_Segments  = segments;

endmodule
